mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory byte-address width.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 core_req_valid/dma_req_valid  input  1  requester has an access pending (two requesters: core=0, dma=1).
REQ-005 core_req_addr/dma_req_addr  input  ADDR_W  byte address.
REQ-006 core_req_we/dma_req_we  input  1  1=store, 0=load.
REQ-007 core_req_size/dma_req_size  input  2  0=byte, 1=half, 2=word; 3 is illegal.
REQ-008 core_req_wdata/dma_req_wdata  input  32  store data, right-aligned.
REQ-009 core_req_ready/dma_req_ready  output  1  request accepted this cycle.
REQ-010 core_rsp_valid/dma_rsp_valid  output  1  one-cycle response pulse.
REQ-011 rsp_rdata  output  32  raw memory word read; shared by both requesters.
REQ-012 rsp_err  output  1  qualifies rsp_valid; access was misaligned or illegal.
REQ-013 mem_addr  output  ADDR_W  word-aligned address (low two bits zero).
REQ-014 mem_we / mem_be  output  1 / 4  write enable / byte-lane enables.
REQ-015 mem_wdata / mem_rdata  output / input  32  lane-shifted store data / combinational read data.

Function
REQ-016 FSM states: ARB_IDLE, ARB_ACCESS, ARB_RESP.
REQ-017 In ARB_IDLE or ARB_RESP with any req_valid high, the winner gets req_ready=1 for exactly one cycle, its request is latched, and the FSM enters ARB_ACCESS.
REQ-018 In ARB_RESP with no req_valid high, the FSM returns to ARB_IDLE.
REQ-019 ARB_ACCESS lasts one cycle: memory is driven from the latched request and mem_rdata is registered into rsp_rdata; the FSM then enters ARB_RESP.
REQ-020 In ARB_RESP, the latched owner's rsp_valid=1 for one cycle.
REQ-021 Latency is acceptance at N, memory cycle at N+1, rsp_valid at N+2; back-to-back issue interval is 2 cycles.
REQ-022 Byte lanes: mem_be = 0001<<a[1:0] for byte, 0011<<a[1:0] for half, 1111 for word; mem_wdata = wdata<<(8*a[1:0]).
REQ-023 A half access with a[0]=1, a word access with a[1:0]!=0, or size=3 is an error: mem_we=0 and mem_be=0 in ARB_ACCESS, and rsp_err=1 with the response.
REQ-024 Outside ARB_ACCESS: mem_we=0 and mem_be=0; mem_addr and mem_wdata hold their last values.
REQ-025 A requester keeps valid and its fields stable until ready; the arbiter samples them only in the ready cycle.
REQ-026 When both requesters are valid in the same cycle, the priority rule in REQ-031 applies; the loser's ready stays 0.
REQ-027 Loads complete with mem_be=0 and mem_we=0 on the memory port; lane extraction is the requester's job.

Reset
REQ-028 Under reset: FSM=ARB_IDLE, all ready and rsp_valid outputs = 0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, and the round-robin pointer = core.
REQ-029 Reset asserted in ARB_ACCESS or ARB_RESP aborts the access; no write reaches memory in the reset cycle and no rsp_valid follows.

Configuration
REQ-030 The macro MEM_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-031 With the macro defined, a contention winner is the requester not granted last; the pointer updates on every accept. Without it, core has fixed priority and the pointer logic is absent.

Structure
REQ-032 The shared types package holds the arb_state_t enum (ARB_IDLE/ARB_ACCESS/ARB_RESP), mem_size_t (MEM_SIZE__BYTE/HALF/WORD), and the requester ID constants.
REQ-033 One sub-module, mem_lane_gen, holds the combinational be/wdata/misalign logic of REQ-022 and REQ-023.

Verification
REQ-034 Core word store at addr 0x10, wdata 0xDEADBEEF -> ready at N; at N+1 mem_addr=0x10, be=1111, we=1; core_rsp_valid at N+2 with err=0.
REQ-035 DMA byte store at 0x13, wdata 0xA5 -> mem_addr=0x10, be=1000, mem_wdata=0xA5000000.
REQ-036 Core half load at 0x21 -> we=0, be=0, core_rsp_valid with rsp_err=1.
REQ-037 Both requesters valid continuously for 4 grants -> with the macro, grants alternate C,D,C,D; without it, core only; accepts 2 cycles apart.
REQ-038 Reset asserted in the ARB_ACCESS cycle of a store -> mem_we=0, no rsp_valid, FSM=ARB_IDLE on the next cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states, access
// sizes and requester IDs.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    MEM_SIZE__BYTE = 2'd0,
    MEM_SIZE__HALF = 2'd1,
    MEM_SIZE__WORD = 2'd2
  } mem_size_t;

  localparam logic REQ_ID_CORE = 1'b0;
  localparam logic REQ_ID_DMA  = 1'b1;

endpackage

// File: rtl/mem_lane_gen.sv
// Byte-lane enables, lane-shifted store data and misalignment detection
// for one memory access. Purely combinational.
module mem_lane_gen
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic        misalign
);

  logic [3:0] be_raw;

  // Lane mask per size; illegal size and unaligned half/word flag an error.
  // Loads and errored accesses enable no lanes.
  always_comb begin
    be_raw   = 4'b0000;
    misalign = 1'b0;
    case (size)
      MEM_SIZE__BYTE: be_raw = 4'b0001 << addr_lo;
      MEM_SIZE__HALF: begin
        be_raw   = 4'b0011 << addr_lo;
        misalign = addr_lo[0];
      end
      MEM_SIZE__WORD: begin
        be_raw   = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
    be       = (we && !misalign) ? be_raw : 4'b0000;
    wdata_sh = wdata << {addr_lo, 3'b000};
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (core, dma) single-port memory arbiter.
// Accept at N, memory cycle at N+1, response pulse at N+2.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise core has fixed priority.
//
// state      | meaning
// ARB_IDLE   | nothing in flight, ready to accept
// ARB_ACCESS | memory driven from latched request, read data captured
// ARB_RESP   | response pulse to owner, may accept the next request
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req_valid,
  input  logic [ADDR_W-1:0] core_req_addr,
  input  logic              core_req_we,
  input  logic [1:0]        core_req_size,
  input  logic [31:0]       core_req_wdata,
  output logic              core_req_ready,
  output logic              core_rsp_valid,
  input  logic              dma_req_valid,
  input  logic [ADDR_W-1:0] dma_req_addr,
  input  logic              dma_req_we,
  input  logic [1:0]        dma_req_size,
  input  logic [31:0]       dma_req_wdata,
  output logic              dma_req_ready,
  output logic              dma_rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  arb_state_t        state, state_nxt;
  logic              lat_owner;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [1:0]        lat_size;
  logic [31:0]       lat_wdata;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic              any_valid;
  logic              accept;
  logic              win_dma;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic              lane_err;

  assign any_valid = core_req_valid | dma_req_valid;
  assign accept    = any_valid && !reset &&
                     ((state == ARB_IDLE) || (state == ARB_RESP));

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic rr_next;

  // Round-robin pointer: the requester favoured on the next contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_next <= REQ_ID_CORE;
    end else if (accept) begin
      rr_next <= win_dma ? REQ_ID_CORE : REQ_ID_DMA;
    end
  end

  assign win_dma = dma_req_valid && (!core_req_valid || (rr_next == REQ_ID_DMA));
`else
  assign win_dma = dma_req_valid && !core_req_valid;
`endif

  mem_lane_gen u_lane (
    .addr_lo  (lat_addr[1:0]),
    .size     (lat_size),
    .we       (lat_we),
    .wdata    (lat_wdata),
    .be       (lane_be),
    .wdata_sh (lane_wdata),
    .misalign (lane_err)
  );

  // Memory address and data come straight from the latch so they hold
  // their last value until the next accept.
  assign mem_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata = lane_wdata;
  assign rsp_rdata = rdata_q;

  // State register, request latch and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      lat_owner <= REQ_ID_CORE;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_size  <= 2'b00;
      lat_wdata <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_owner <= win_dma ? REQ_ID_DMA : REQ_ID_CORE;
        lat_addr  <= win_dma ? dma_req_addr  : core_req_addr;
        lat_we    <= win_dma ? dma_req_we    : core_req_we;
        lat_size  <= win_dma ? dma_req_size  : core_req_size;
        lat_wdata <= win_dma ? dma_req_wdata : core_req_wdata;
      end
      if (state == ARB_ACCESS) begin
        rdata_q <= mem_rdata;
        err_q   <= lane_err;
      end
    end
  end

  // Next state and per-state outputs; reset gates every strobe so an
  // aborted access never reaches memory or the requester.
  always_comb begin
    state_nxt      = state;
    core_req_ready = accept && !win_dma;
    dma_req_ready  = accept && win_dma;
    mem_we         = 1'b0;
    mem_be         = 4'b0000;
    core_rsp_valid = 1'b0;
    dma_rsp_valid  = 1'b0;
    rsp_err        = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (any_valid) state_nxt = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        state_nxt = ARB_RESP;
        if (!reset) begin
          mem_we = lat_we && !lane_err;
          mem_be = lane_be;
        end
      end
      ARB_RESP: begin
        state_nxt = any_valid ? ARB_ACCESS : ARB_IDLE;
        if (!reset) begin
          core_rsp_valid = (lat_owner == REQ_ID_CORE);
          dma_rsp_valid  = (lat_owner == REQ_ID_DMA);
          rsp_err        = err_q;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

endmodule
